mar_addr_seq: RTL and testbench

//  Parametrised successor to the MAR source mux. Selects the memory address
//  (EAB, extended trap vector, interrupt vector, or held MAR) and registers it
//  in MAR. Issues single or burst memory requests with a req/ack handshake,

---
 rtl/mar_addr_seq_pkg.sv | 19 +
 rtl/mar_addr_seq_if.sv | 13 +
 rtl/mar_addr_seq_vec_ext.sv | 16 +
 rtl/mar_addr_seq.sv | 112 +++++++++++
 tb/tb_mar_addr_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mar_addr_seq_pkg.sv
// Shared encodings for the MAR address sequencer: source selects, FSM states,
// and the default interrupt vector table base.
package mar_addr_seq_pkg;

  typedef enum logic [1:0] {
    MAR_SEL_EAB  = 2'd0,
    MAR_SEL_TRAP = 2'd1,
    MAR_SEL_INT  = 2'd2,
    MAR_SEL_HOLD = 2'd3
  } mar_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } seq_state_e;

  localparam int DEF_INT_BASE = 'h0100;

endpackage

// File: rtl/mar_addr_seq_if.sv
// Memory request bus between the address sequencer (master) and memory (slave).
interface mar_addr_seq_if #(
  parameter int ADDR_W = 16
) ();

  logic [ADDR_W-1:0] mar;
  logic              mem_req;
  logic              mem_ack;

  modport master (output mar, output mem_req, input mem_ack);
  modport slave  (input mar, input mem_req, output mem_ack);

endinterface

// File: rtl/mar_addr_seq_vec_ext.sv
// Widens an IR vector field to a full address, zero- or sign-extending it.
module mar_vec_ext #(
  parameter int VEC_W    = 8,
  parameter int ADDR_W   = 16,
  parameter bit VEC_SEXT = 1'b0
) (
  input  logic [VEC_W-1:0]  i_vec,
  output logic [ADDR_W-1:0] o_addr
);

  logic w_fill;

  assign w_fill = VEC_SEXT ? i_vec[VEC_W-1] : 1'b0;
  assign o_addr = {{(ADDR_W-VEC_W){w_fill}}, i_vec};

endmodule

// File: rtl/mar_addr_seq.sv
// MAR source mux plus single/burst request sequencer; MAR post-increments on
// every accepted beat except the last, so it holds the final beat address.
module mar_addr_seq
  import mar_addr_seq_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                VEC_W    = 8,
  parameter bit                VEC_SEXT = 1'b0,
  parameter logic [ADDR_W-1:0] INT_BASE = ADDR_W'(DEF_INT_BASE),
  parameter int                BURST_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VEC_W-1:0]   i_ir_vec,
  input  logic [VEC_W-1:0]   i_int_vec,
  input  logic [ADDR_W-1:0]  i_eab,
  input  logic [1:0]         i_sel,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic               i_start,
  input  logic               i_abort,
  mar_addr_seq_if.master     mem,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun
);

  seq_state_e          r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_mar,       w_mar_nxt;
  logic [BURST_W-1:0]  r_remaining, w_remaining_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_overrun,   w_overrun_nxt;
  logic [ADDR_W-1:0]   w_trap_addr;
  logic [ADDR_W-1:0]   w_int_addr;
  logic [ADDR_W-1:0]   w_src;

  mar_vec_ext #(
    .VEC_W    (VEC_W),
    .ADDR_W   (ADDR_W),
    .VEC_SEXT (VEC_SEXT)
  ) u_vec_ext (
    .i_vec  (i_ir_vec),
    .o_addr (w_trap_addr)
  );

  // Interrupt vector table entry wraps modulo 2**ADDR_W.
  assign w_int_addr = INT_BASE + {{(ADDR_W-VEC_W){1'b0}}, i_int_vec};

  always_comb begin
    w_src = r_mar;
    unique case (mar_sel_e'(i_sel))
      MAR_SEL_EAB:  w_src = i_eab;
      MAR_SEL_TRAP: w_src = w_trap_addr;
      MAR_SEL_INT:  w_src = w_int_addr;
      MAR_SEL_HOLD: w_src = r_mar;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mar_nxt       = r_mar;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    w_overrun_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_mar_nxt       = w_src;
          w_remaining_nxt = (i_burst_len == '0) ? BURST_W'(1) : i_burst_len;
          w_state_nxt     = ST_REQ;
        end
      end
      ST_REQ: begin
        w_overrun_nxt = i_start;
        // Abort takes priority: a coincident ack is treated as not accepted.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (mem.mem_ack) begin
          if (r_remaining > BURST_W'(1)) begin
            w_mar_nxt       = r_mar + ADDR_W'(1);
            w_remaining_nxt = r_remaining - BURST_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mar       <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mar       <= w_mar_nxt;
      r_remaining <= w_remaining_nxt;
      r_done      <= w_done_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign mem.mar     = r_mar;
  assign mem.mem_req = (r_state == ST_REQ);
  assign o_busy      = (r_state == ST_REQ);
  assign o_done      = r_done;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_mar_addr_seq.sv
// Directed bench for mar_addr_seq: a zero-extend instance drives all scenarios,
// a sign-extend instance self-acks and is checked for the trap vector extension.
module tb_mar_addr_seq;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ir_vec;
  logic [7:0]  int_vec;
  logic [15:0] eab;
  logic [1:0]  sel;
  logic [2:0]  burst_len;
  logic        start;
  logic        abort;
  logic        busy0, done0, ovr0;
  logic        busy1, done1, ovr1;

  int n_checks = 0;
  int n_errors = 0;

  mar_addr_seq_if #(.ADDR_W(16)) if0 ();
  mar_addr_seq_if #(.ADDR_W(16)) if1 ();

  assign if1.mem_ack = if1.mem_req;

  mar_addr_seq #(.ADDR_W(16), .VEC_W(8), .VEC_SEXT(1'b0), .INT_BASE(16'h0100), .BURST_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_ir_vec(ir_vec), .i_int_vec(int_vec), .i_eab(eab),
    .i_sel(sel), .i_burst_len(burst_len), .i_start(start), .i_abort(abort),
    .mem(if0.master), .o_busy(busy0), .o_done(done0), .o_overrun(ovr0)
  );

  mar_addr_seq #(.ADDR_W(16), .VEC_W(8), .VEC_SEXT(1'b1), .INT_BASE(16'h0100), .BURST_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_ir_vec(ir_vec), .i_int_vec(int_vec), .i_eab(eab),
    .i_sel(sel), .i_burst_len(burst_len), .i_start(start), .i_abort(abort),
    .mem(if1.master), .o_busy(busy1), .o_done(done1), .o_overrun(ovr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] mar, input logic req,
                         input logic done, input logic ovr);
    chk({tag, ".mar"},  {16'h0, if0.mar}, {16'h0, mar});
    chk({tag, ".req"},  {31'h0, if0.mem_req}, {31'h0, req});
    chk({tag, ".busy"}, {31'h0, busy0}, {31'h0, req});
    chk({tag, ".done"}, {31'h0, done0}, {31'h0, done});
    chk({tag, ".ovr"},  {31'h0, ovr0}, {31'h0, ovr});
  endtask

  initial begin
    rst_n = 1'b0; ir_vec = '0; int_vec = '0; eab = '0; sel = '0;
    burst_len = '0; start = 1'b0; abort = 1'b0; if0.mem_ack = 1'b0;
    tick(); tick();
    chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Trap vector 0x25, single beat
    sel = 2'd1; ir_vec = 8'h25; burst_len = 3'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("trap25.req", 16'h0025, 1'b1, 1'b0, 1'b0);
    chk("trap25.sext_mar", {16'h0, if1.mar}, 32'h0025);
    if0.mem_ack = 1'b1;
    tick(); if0.mem_ack = 1'b0;
    chk_out("trap25.done", 16'h0025, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("trap25.idle", 16'h0025, 1'b0, 1'b0, 1'b0);

    // Trap vector 0xF0: zero- vs sign-extension
    ir_vec = 8'hF0; start = 1'b1;
    tick(); start = 1'b0;
    chk("trapF0.zext", {16'h0, if0.mar}, 32'h00F0);
    chk("trapF0.sext", {16'h0, if1.mar}, 32'hFFF0);
    if0.mem_ack = 1'b1;
    tick(); if0.mem_ack = 1'b0;
    chk_out("trapF0.done", 16'h00F0, 1'b0, 1'b1, 1'b0);

    // Interrupt vector 0x80 -> 0x0180, request held until ack
    sel = 2'd2; int_vec = 8'h80; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("int80.req", 16'h0180, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("int80.wait", 16'h0180, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1;
    tick(); if0.mem_ack = 1'b0;
    chk_out("int80.done", 16'h0180, 1'b0, 1'b1, 1'b0);

    // EAB burst of 3 from 0xFFFE, ack every 2nd cycle, wraps to 0
    sel = 2'd0; eab = 16'hFFFE; burst_len = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("burst.b0", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("burst.b0w", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick(); if0.mem_ack = 1'b0;
    chk_out("burst.b1", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("burst.b1w", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick(); if0.mem_ack = 1'b0;
    chk_out("burst.b2", 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("burst.b2w", 16'h0000, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick(); if0.mem_ack = 1'b0;
    chk_out("burst.done", 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("burst.idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Start while busy -> overrun, burst unaffected
    eab = 16'h1234; burst_len = 3'd2; start = 1'b1;
    tick();
    eab = 16'h5555;
    tick(); start = 1'b0;
    chk_out("ovr.pulse", 16'h1234, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("ovr.clear", 16'h1234, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick();
    chk_out("ovr.b1", 16'h1235, 1'b1, 1'b0, 1'b0);
    tick(); if0.mem_ack = 1'b0;
    chk_out("ovr.done", 16'h1235, 1'b0, 1'b1, 1'b0);

    // Start coincident with final ack is ignored but flagged
    eab = 16'h2000; burst_len = 3'd1; start = 1'b1;
    tick();
    if0.mem_ack = 1'b1;
    tick(); start = 1'b0; if0.mem_ack = 1'b0;
    chk_out("ovr.final", 16'h2000, 1'b0, 1'b1, 1'b1);

    // Abort beats a same-cycle ack
    eab = 16'h0040; burst_len = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    if0.mem_ack = 1'b1; tick();
    chk_out("abort.b1", 16'h0041, 1'b1, 1'b0, 1'b0);
    abort = 1'b1;
    tick(); abort = 1'b0; if0.mem_ack = 1'b0;
    chk_out("abort.idle", 16'h0041, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("abort.nodone", 16'h0041, 1'b0, 1'b0, 1'b0);

    // Abort and ack in IDLE are no-ops
    abort = 1'b1; if0.mem_ack = 1'b1;
    tick(); abort = 1'b0; if0.mem_ack = 1'b0;
    chk_out("idle.noop", 16'h0041, 1'b0, 1'b0, 1'b0);

    // Start+abort in IDLE: start wins; burst_len 0 acts as 1
    eab = 16'h0077; burst_len = 3'd0; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk_out("sa.req", 16'h0077, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick(); if0.mem_ack = 1'b0;
    chk_out("sa.done", 16'h0077, 1'b0, 1'b1, 1'b0);

    // Hold MAR source
    sel = 2'd3; eab = 16'hAAAA; burst_len = 3'd1; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("hold.req", 16'h0077, 1'b1, 1'b0, 1'b0);
    if0.mem_ack = 1'b1; tick(); if0.mem_ack = 1'b0;

    // Async reset mid-burst
    sel = 2'd0; eab = 16'h0200; burst_len = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    if0.mem_ack = 1'b1; tick();
    chk_out("rst.pre", 16'h0201, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk_out("rst.hold", 16'h0000, 1'b0, 1'b0, 1'b0);
    if0.mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_out("rst.after", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
